// File: rtl/band_peak_finder_if.sv
// Bin-stream input and peak-stream output bundle for band_peak_finder.
// The master side feeds bins and accepts peaks; the slave side is the finder itself.
interface band_peak_finder_if;
  logic [15:0] magnitude;
  logic        magnitude_ready;
  logic [8:0]  index;
  logic        frame_done;
  logic        peak_valid;
  logic        peak_ready;
  logic [2:0]  peak_band;
  logic [8:0]  peak_index;
  logic [15:0] peak_mag;
  logic        frame_end;
  logic [7:0]  frame_id;
  logic        overflow;

  modport master (
    output magnitude, magnitude_ready, index, frame_done, peak_ready,
    input  peak_valid, peak_band, peak_index, peak_mag, frame_end, frame_id, overflow
  );

  modport slave (
    input  magnitude, magnitude_ready, index, frame_done, peak_ready,
    output peak_valid, peak_band, peak_index, peak_mag, frame_end, frame_id, overflow
  );
endinterface

// File: rtl/band_peak_finder.sv
// Per-frame band peak finder: tracks the largest bin magnitude in each of six
// frequency bands, then streams out every band peak at or above THRESHOLD
// over a valid/ready handshake, followed by a one-cycle frame_end pulse.
module band_peak_finder #(
  parameter logic [15:0] THRESHOLD = 16'd64
) (
  input logic              clk,
  input logic              reset,
  band_peak_finder_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, EMIT, END} state_t;

  localparam logic [2:0] LAST_BAND = 3'd5;

  state_t      state;
  state_t      state_next;
  logic [2:0]  p;
  logic [15:0] band_max [0:5];
  logic [8:0]  band_idx [0:5];
  logic [2:0]  sample_band;
  logic        sample_take;
  logic        emit_load;
  logic        emit_step;

  logic        peak_valid_q;
  logic [2:0]  peak_band_q;
  logic [8:0]  peak_index_q;
  logic [15:0] peak_mag_q;
  logic        frame_end_q;
  logic [7:0]  frame_id_q;
  logic        overflow_q;

  // Map a bin number to its band; bin 0 (DC) is filtered out by the caller.
  function automatic logic [2:0] band_of(input logic [8:0] idx);
    if (idx <= 9'd10)       return 3'd0;
    else if (idx <= 9'd20)  return 3'd1;
    else if (idx <= 9'd40)  return 3'd2;
    else if (idx <= 9'd80)  return 3'd3;
    else if (idx <= 9'd160) return 3'd4;
    else                    return 3'd5;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next  = state;
    sample_band = band_of(bus.index);
    sample_take = 1'b0;
    emit_load   = 1'b0;
    emit_step   = 1'b0;
    case (state)
      COLLECT: begin
        // A strictly-greater compare keeps the earlier (lower) index on ties.
        sample_take = bus.magnitude_ready && (bus.index != 9'd0) &&
                      (bus.magnitude > band_max[sample_band]);
        if (bus.frame_done) state_next = EMIT;
      end
      EMIT: begin
        if (peak_valid_q) begin
          emit_step = bus.peak_ready;
        end else if (band_max[p] >= THRESHOLD) begin
          emit_load = 1'b1;
        end else begin
          emit_step = 1'b1;
        end
        if (emit_step && (p == LAST_BAND)) state_next = END;
      end
      END:     state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Band trackers, emit pointer, registered outputs and the overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the band trackers are a tiny flop array, not a RAM, and their
      // zero state is functionally required, so they are reset explicitly.
      for (int b = 0; b < 6; b++) begin
        band_max[b] <= '0;
        band_idx[b] <= '0;
      end
      p            <= '0;
      peak_valid_q <= 1'b0;
      peak_band_q  <= '0;
      peak_index_q <= '0;
      peak_mag_q   <= '0;
      frame_end_q  <= 1'b0;
      frame_id_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (sample_take) begin
        band_max[sample_band] <= bus.magnitude;
        band_idx[sample_band] <= bus.index;
      end

      // Leaving END starts a fresh frame, so the trackers are cleared here.
      if (state == END) begin
        for (int b = 0; b < 6; b++) begin
          band_max[b] <= '0;
          band_idx[b] <= '0;
        end
      end

      if (state == COLLECT) p <= '0;

      if (emit_load) begin
        peak_valid_q <= 1'b1;
        peak_band_q  <= p;
        peak_index_q <= band_idx[p];
        peak_mag_q   <= band_max[p];
      end

      if (emit_step) begin
        peak_valid_q <= 1'b0;
        p            <= (p == LAST_BAND) ? 3'd0 : p + 3'd1;
      end

      // frame_end is high exactly while the FSM sits in END.
      frame_end_q <= (state == EMIT) && (state_next == END);
      if ((state == EMIT) && (state_next == END)) frame_id_q <= frame_id_q + 8'd1;

      if ((state != COLLECT) && (bus.magnitude_ready || bus.frame_done)) overflow_q <= 1'b1;
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_band  = peak_band_q;
  assign bus.peak_index = peak_index_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.frame_id   = frame_id_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_band_peak_finder.sv
// Scoreboard bench for band_peak_finder: stimulus pushes expected peaks and
// frame ids into queues, monitors pop and compare when the DUT presents them.
module tb_band_peak_finder;

  typedef struct packed {
    logic [2:0]  band;
    logic [8:0]  idx;
    logic [15:0] mag;
  } peak_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  band_peak_finder_if bus ();

  band_peak_finder #(.THRESHOLD(16'd64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  peak_t       exp_peaks[$];
  logic [7:0]  exp_ids[$];
  logic [15:0] mags [0:511];
  bit          bp_mode = 1'b0;
  int          stall_cnt = 0;
  int          frame_end_cnt = 0;
  int          valid_cycles = 0;
  bit          stall_prev = 1'b0;
  peak_t       held;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Downstream model: always ready, or stalls each peak for 5 cycles.
  always begin
    @(posedge clk);
    #2;
    if (!bp_mode) begin
      bus.peak_ready = 1'b1;
    end else if (bus.peak_valid) begin
      if (stall_cnt < 5) begin
        bus.peak_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.peak_ready = 1'b1;
      end
    end else begin
      bus.peak_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: stability under stall, peak handshakes, frame_end pulses.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      peak_t cur;
      cur = '{bus.peak_band, bus.peak_index, bus.peak_mag};
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, bus.peak_valid}, 32'd1);
        check("stall_fields_held", {4'd0, cur}, {4'd0, held});
      end
      if (bus.peak_valid) valid_cycles++;
      if (bus.peak_valid && bus.peak_ready) begin
        if (exp_peaks.size() == 0) begin
          check("unexpected_peak", {4'd0, cur}, 32'd0);
        end else begin
          check("peak", {4'd0, cur}, {4'd0, exp_peaks.pop_front()});
        end
      end
      if (bus.frame_end) begin
        frame_end_cnt++;
        if (exp_ids.size() == 0) check("unexpected_frame_end", {24'd0, bus.frame_id}, 32'hffff);
        else                     check("frame_id", {24'd0, bus.frame_id}, {24'd0, exp_ids.pop_front()});
      end
      stall_prev = bus.peak_valid && !bus.peak_ready;
      held = cur;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic bin(input logic [8:0] idx, input logic [15:0] mag, input bit fd);
    bus.index           = idx;
    bus.magnitude       = mag;
    bus.magnitude_ready = 1'b1;
    bus.frame_done      = fd;
    @(posedge clk); #1;
    bus.magnitude_ready = 1'b0;
    bus.frame_done      = 1'b0;
  endtask

  task automatic strobe_fd();
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.frame_done = 1'b0;
  endtask

  task automatic fill_mags(input logic [15:0] v);
    for (int i = 0; i < 512; i++) mags[i] = v;
  endtask

  task automatic send_frame(input int last, input bit fd_with_last);
    for (int i = 0; i <= last; i++) bin(i[8:0], mags[i], fd_with_last && (i == last));
    if (!fd_with_last) strobe_fd();
  endtask

  task automatic wait_frame_end(input int target);
    int n = 0;
    while (frame_end_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_end_seen", {31'd0, frame_end_cnt >= target}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_peak_valid"}, {31'd0, bus.peak_valid}, 32'd0);
    check({tag, "_frame_end"},  {31'd0, bus.frame_end}, 32'd0);
    check({tag, "_overflow"},   {31'd0, bus.overflow}, 32'd0);
    check({tag, "_frame_id"},   {24'd0, bus.frame_id}, 32'd0);
    check({tag, "_fields"},     {4'd0, bus.peak_band, bus.peak_index, bus.peak_mag}, 32'd0);
  endtask

  task automatic load_main_frame();
    fill_mags(16'd10);
    mags[5]   = 16'd100;
    mags[15]  = 16'd200;
    mags[300] = 16'd500;
  endtask

  task automatic push_main_peaks();
    exp_peaks.push_back('{3'd0, 9'd5, 16'd100});
    exp_peaks.push_back('{3'd1, 9'd15, 16'd200});
    exp_peaks.push_back('{3'd5, 9'd300, 16'd500});
  endtask

  initial begin
    int fe_before;
    int n;
    int vc_before;
    bus.magnitude       = '0;
    bus.magnitude_ready = 1'b0;
    bus.index           = '0;
    bus.frame_done      = 1'b0;
    bus.peak_ready      = 1'b1;
    do_reset();
    check_reset_values("reset");

    // Basic frame, ready always high.
    load_main_frame();
    push_main_peaks();
    exp_ids.push_back(8'd1);
    send_frame(511, 1'b0);
    wait_frame_end(1);
    check("main_overflow", {31'd0, bus.overflow}, 32'd0);

    // Tie: lower index wins.
    fill_mags(16'd0);
    mags[41] = 16'd900;
    mags[60] = 16'd900;
    exp_peaks.push_back('{3'd3, 9'd41, 16'd900});
    exp_ids.push_back(8'd2);
    send_frame(511, 1'b0);
    wait_frame_end(2);

    // Backpressure: 5 stalled cycles per peak.
    bp_mode = 1'b1;
    load_main_frame();
    push_main_peaks();
    exp_ids.push_back(8'd3);
    send_frame(511, 1'b0);
    wait_frame_end(3);
    bp_mode = 1'b0;
    check("bp_overflow", {31'd0, bus.overflow}, 32'd0);

    // Band edges, threshold edge (64 kept, 63 dropped), DC ignored.
    fill_mags(16'd0);
    mags[0]   = 16'd1000;
    mags[10]  = 16'd64;
    mags[11]  = 16'd63;
    mags[21]  = 16'd65;
    mags[40]  = 16'd70;
    mags[41]  = 16'd10;
    mags[80]  = 16'd64;
    mags[81]  = 16'd100;
    mags[160] = 16'd100;
    mags[161] = 16'd998;
    mags[511] = 16'd999;
    exp_peaks.push_back('{3'd0, 9'd10, 16'd64});
    exp_peaks.push_back('{3'd2, 9'd40, 16'd70});
    exp_peaks.push_back('{3'd3, 9'd80, 16'd64});
    exp_peaks.push_back('{3'd4, 9'd81, 16'd100});
    exp_peaks.push_back('{3'd5, 9'd511, 16'd999});
    exp_ids.push_back(8'd4);
    send_frame(511, 1'b0);
    wait_frame_end(4);

    // Drop: a strobe during EMIT sets overflow, peaks unaffected.
    fill_mags(16'd0);
    mags[5]  = 16'd100;
    mags[15] = 16'd200;
    exp_peaks.push_back('{3'd0, 9'd5, 16'd100});
    exp_peaks.push_back('{3'd1, 9'd15, 16'd200});
    exp_ids.push_back(8'd5);
    send_frame(511, 1'b0);
    bin(9'd300, 16'd5000, 1'b0);
    wait_frame_end(5);
    check("drop_overflow", {31'd0, bus.overflow}, 32'd1);

    // frame_done together with the last bin: the sample still counts.
    fill_mags(16'd0);
    mags[200] = 16'd700;
    exp_peaks.push_back('{3'd5, 9'd200, 16'd700});
    exp_ids.push_back(8'd6);
    send_frame(200, 1'b1);
    wait_frame_end(6);
    check("sticky_overflow", {31'd0, bus.overflow}, 32'd1);

    // Reset while a peak is stalled in EMIT: no frame_end, all cleared.
    bp_mode = 1'b1;
    fill_mags(16'd0);
    mags[5] = 16'd100;
    send_frame(20, 1'b0);
    n = 0;
    while (!bus.peak_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_reset_valid", {31'd0, bus.peak_valid}, 32'd1);
    fe_before = frame_end_cnt;
    do_reset();
    bp_mode = 1'b0;
    check_reset_values("midemit");
    repeat (20) @(posedge clk);
    #1;
    check("midemit_no_frame_end", frame_end_cnt, fe_before);

    // Wrap: 256 empty frames, frame_id returns to 0, no peaks.
    vc_before = valid_cycles;
    for (int f = 1; f <= 256; f++) begin
      logic [7:0] id;
      id = f[7:0];
      exp_ids.push_back(id);
      strobe_fd();
      wait_frame_end(fe_before + f);
    end
    check("wrap_frame_id", {24'd0, bus.frame_id}, 32'd0);
    check("wrap_no_valid", valid_cycles, vc_before);
    check("wrap_overflow", {31'd0, bus.overflow}, 32'd0);
    check("peak_queue_empty", exp_peaks.size(), 0);
    check("id_queue_empty", exp_ids.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/band_peak_finder.md
BAND_PEAK_FINDER -- requirements
Module: band_peak_finder

Interface
REQ-001 Parameter THRESHOLD, 16'd64: minimum band-peak magnitude that is emitted.
REQ-002 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low.
REQ-004 magnitude  input  16  FFT bin magnitude; valid while magnitude_ready=1.
REQ-005 magnitude_ready  input  1  one-cycle strobe, one strobe per bin.
REQ-006 index  input  9  bin number 0..511 of the current magnitude.
REQ-007 frame_done  input  1  one-cycle strobe marking the end of one FFT frame's bins.
REQ-008 peak_valid  output  1  the peak_* fields hold a valid peak.
REQ-009 peak_ready  input  1  downstream accepts the peak when peak_valid=1 and peak_ready=1.
REQ-010 peak_band  output  3  band number 0..5.
REQ-011 peak_index  output  9  bin index of the band maximum.
REQ-012 peak_mag  output  16  magnitude of the band maximum.
REQ-013 frame_end  output  1  one-cycle pulse after the last peak of a frame.
REQ-014 frame_id  output  8  frame counter; increments on every frame_end.
REQ-015 overflow  output  1  sticky flag: an input was dropped.

Function
REQ-016 Band map, inclusive: band 0 = bins 1-10; band 1 = 11-20; band 2 = 21-40; band 3 = 41-80; band 4 = 81-160; band 5 = 161-511.
REQ-017 Bin 0 (DC) is ignored and shall never update a band.
REQ-018 States: COLLECT, EMIT and END; the block enters COLLECT on leaving reset.
REQ-019 In COLLECT, each magnitude_ready strobe is handled as follows.
- If magnitude > band_max[b] (strictly greater), the block stores magnitude and index for that band.
- On a tie, the lower index, which arrived first, is kept.
REQ-020 Every band_max register is cleared to 0 and every band_idx register to 0 at the start of each frame, meaning on entry to COLLECT.
REQ-021 If frame_done and magnitude_ready are asserted in the same cycle, the sample is folded in first, then the block goes COLLECT->EMIT on the next edge.
REQ-022 EMIT scans the bands in order 0..5, with band pointer p, as follows.
- If band_max[p] >= THRESHOLD: drive peak_valid=1 with band p's fields and hold them stable until peak_ready=1.
- Otherwise: skip band p in one cycle with peak_valid=0.
REQ-023 A handshake (peak_valid & peak_ready) advances p on the next edge; the first peak appears 1 cycle after EMIT entry.
REQ-024 After p=5 completes, the block enters END.
- END asserts frame_end for exactly 1 cycle and increments frame_id (wrapping 255->0).
- The block then returns to COLLECT.
REQ-025 A frame in which no band reaches the threshold produces no peak_valid but still produces frame_end and a frame_id increment.
REQ-026 Any magnitude_ready or frame_done strobe arriving in EMIT or END is dropped and sets overflow=1.
REQ-027 overflow is cleared only by reset.
REQ-028 A frame_done strobe with no preceding bins shall still run EMIT; all bands are 0, so only frame_end is produced.
REQ-029 Outputs are registered; peak_* fields shall not change while peak_valid=1 and peak_ready=0.
REQ-030 Index values outside 1..511 cannot occur except 0, which is covered by REQ-017.

Reset
REQ-031 Synchronous reset has priority over every other input; reset mid-EMIT aborts the frame without emitting frame_end.
REQ-032 Reset values:
- peak_valid=0, frame_end=0, overflow=0, frame_id=0;
- peak_band, peak_index and peak_mag all 0;
- all band_max and band_idx registers 0; state=COLLECT.

Verification
REQ-033 Single frame, peak_ready tied to 1.
- Stimulus: bins 1..511 at value 10, except bin 5=100, bin 15=200, bin 300=500; then frame_done.
- Required: exactly 3 peaks, (0,5,100), (1,15,200) and (5,300,500), then frame_end; frame_id=1.
REQ-034 Tie.
- Stimulus: bins 41 and 60 both = 900, all other bins 0.
- Required: a single peak (3,41,900).
REQ-035 Backpressure.
- Stimulus: same as REQ-033 with peak_ready=0 for 5 cycles on each peak.
- Required: fields stay stable while stalled; the same 3 peaks arrive in order.
- Required: overflow=0 if no input arrives during EMIT.
REQ-036 Drop.
- Stimulus: a magnitude_ready strobe during EMIT.
- Required: overflow=1 and remains 1 through later frames; the current frame's peaks are unchanged.
REQ-037 Simultaneous end and reset.
- Stimulus: frame_done in the same cycle as the bin-200 strobe of value 700.
- Required: peak (5,200,700).
- Stimulus: reset asserted mid-EMIT.
- Required: outputs return to REQ-032 values and no frame_end.
REQ-038 Wrap.
- Stimulus: 256 empty frames (frame_done only).
- Required: 256 frame_end pulses, no peak_valid, frame_id=0.
